// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the legality/alignment helpers used when a request is accepted.
package lsu_pkg;

    // RV32I load/store funct3 encodings (stores reuse B/H/W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Halfwords need an even address, words a multiple of four; bytes are
    // always aligned. Size code 2'b11 is never legal so its value is moot.
    function automatic logic f3_aligned(input logic [2:0] funct3,
                                        input logic [1:0] byte_off);
        logic ok;
        case (funct3[1:0])
            2'b01:   ok = ~byte_off[0];
            2'b10:   ok = (byte_off == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Loads accept the signed and unsigned byte/half forms, stores only B/H/W
    function automatic logic f3_legal(input logic       we,
                                      input logic [2:0] funct3);
        logic ok;
        if (we) begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            ok = (funct3 == F3_B)  || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between the 32-bit memory word and the core:
// extract+extend for loads, read-modify-write merge for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] wsrc;
    logic [3:0]  byte_en;

    // Select the addressed lane of the read word and sign/zero extend it
    always_comb begin
        sel_byte = rd_word[8*byte_off +: 8];
        sel_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_HU:   load_data = {16'h0, sel_half};
            default: load_data = rd_word;
        endcase
    end

    // Byte enables plus store data replicated onto every candidate lane
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                byte_en = 4'b0001 << byte_off;
                wsrc    = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en = byte_off[1] ? 4'b1100 : 4'b0011;
                wsrc    = {2{wdata[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wsrc    = wdata;
            end
        endcase
    end

    // Enabled lanes take the new data, the rest keep what was read
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[8*gi +: 8] = byte_en[gi] ? wsrc[8*gi +: 8]
                                                   : rd_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between execute and a word-wide unified memory.
// One request at a time; sub-word stores are done as read-modify-write
// because the memory always writes a full word.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wen,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_wen_q, mem_wen_d;

    logic [ADDR_W-1:0] req_aligned;
    logic              req_bad;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    assign req_aligned = {req_addr[ADDR_W-1:2], 2'b00};
    assign req_bad     = !f3_legal(req_we, req_funct3) ||
                         !f3_aligned(req_funct3, req_addr[1:0]) ||
                         (req_aligned >= MEM_LIMIT);

    lsu_lane_align u_lane_align (
        .rd_word   (mem_rdata),
        .funct3    (f3_q),
        .byte_off  (off_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // Next-state and registered-output logic for the request sequencer
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wen_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    f3_d        = req_funct3;
                    off_d       = req_addr[1:0];
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (req_bad) begin
                        // Errors never touch memory; respond next cycle
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        mem_addr_d = req_aligned;
                        if (req_we && (req_funct3 == F3_W)) begin
                            // Full-word store needs no read phase
                            state_d     = WR;
                            mem_wdata_d = req_wdata;
                            mem_wen_d   = 1'b1;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            RD: begin
                if (!we_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                end else begin
                    state_d     = WR;
                    mem_wdata_d = merged;
                    mem_wen_d   = 1'b1;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any request in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            mem_wen_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wen_q    <= mem_wen_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wen    = mem_wen_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, two hand-written
// multi-cycle sequences, then random traffic against a byte-array model.
module tb_load_store_unit;

    localparam int MEM_BYTES = 128;
    localparam int ADDR_W    = 32;

    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;
    localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [MEM_BYTES/4] = '{default: 32'h0};
    logic [7:0]  ref_mem [MEM_BYTES];

    int          wen_cnt  = 0;
    int          resp_cnt = 0;
    logic [31:0] wen_addr_s = 32'h0;
    logic [31:0] wen_data_s = 32'h0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_wword;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wen    (mem_wen),
        .mem_rdata  (mem_rdata)
    );

    // Word-wide memory: combinational read, full-word synchronous write
    assign mem_rdata = mem[mem_addr[6:2]];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr[6:2]] <= mem_wdata;
    end

    // Count write strobes and responses mid-cycle
    always @(negedge clk) begin
        if (mem_wen) begin
            wen_cnt    <= wen_cnt + 1;
            wen_addr_s <= mem_addr;
            wen_data_s <= mem_wdata;
        end
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic err, input int lat, input logic [31:0] wword);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat; v.exp_wword = wword;
        return v;
    endfunction

    // Reference: byte-addressed little-endian memory with RV32I rules
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                         output int lat, output int wens, output logic [31:0] wword);
        int          size;
        bit          legal;
        logic [31:0] base;
        logic [31:0] val;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        base  = addr - (addr % 4);
        err   = !legal || ((addr % size) != 0) || (base >= MEM_BYTES);
        rdata = 32'h0; wword = 32'h0; wens = 0; lat = 1;
        if (!err && !we) begin
            val = 32'h0;
            for (int i = 0; i < size; i++) val = val | (32'(ref_mem[addr + i]) << (8 * i));
            if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8 * size));
            rdata = val;
            lat   = 2;
        end else if (!err) begin
            for (int i = 0; i < size; i++) ref_mem[addr + i] = 8'(wdata >> (8 * i));
            for (int i = 0; i < 4; i++) wword = wword | (32'(ref_mem[base + i]) << (8 * i));
            lat  = (size == 4) ? 2 : 3;
            wens = 1;
        end
    endtask

    // One request: present, accept, time the response, return to IDLE
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic e,
                          output int lat, output int wens);
        int w0;
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("ready_before_req", 32'(req_ready), 32'd1);
        w0 = wen_cnt;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        e  = resp_err;
        @(posedge clk); #1;
        wens = wen_cnt - w0;
        chk("valid_one_cycle", 32'(resp_valid), 32'd0);
        chk("ready_after_resp", 32'(req_ready), 32'd1);
        $display("txn we=%0d f3=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d wens=%0d",
                 we, f3, a, wd, rd, e, lat, wens);
    endtask

    initial begin
        logic [31:0] rd, m_rd, m_ww, m_waddr;
        logic        e, m_e;
        int          lat, wens, m_lat, m_wens;
        int          w0, r0;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        logic [5:0]  exp_ready, exp_wen, exp_valid;

        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h0;

        // Reset values
        #2 rst = 1'b0;
        #1;
        chk("rst_req_ready",  32'(req_ready),  32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err",   32'(resp_err),   32'd0);
        chk("rst_resp_rdata", resp_rdata,      32'h0);
        chk("rst_mem_wen",    32'(mem_wen),    32'd0);
        chk("rst_mem_addr",   mem_addr,        32'h0);
        chk("rst_mem_wdata",  mem_wdata,       32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        vecs.push_back(mk(1, SW,    32'h10, 32'h8877_6655, 32'h0,         0, 2, 32'h8877_6655));
        vecs.push_back(mk(0, LB,    32'h13, 32'h0,         32'hFFFF_FF88, 0, 2, 32'h0));
        vecs.push_back(mk(0, LBU,   32'h13, 32'h0,         32'h0000_0088, 0, 2, 32'h0));
        vecs.push_back(mk(0, LW,    32'h10, 32'h0,         32'h8877_6655, 0, 2, 32'h0));
        vecs.push_back(mk(1, SW,    32'h20, 32'hAABB_CCDD, 32'h0,         0, 2, 32'hAABB_CCDD));
        vecs.push_back(mk(1, SB,    32'h21, 32'hFFFF_FF11, 32'h0,         0, 3, 32'hAABB_11DD));
        vecs.push_back(mk(0, LW,    32'h20, 32'h0,         32'hAABB_11DD, 0, 2, 32'h0));
        vecs.push_back(mk(1, SW,    32'h20, 32'h0,         32'h0,         0, 2, 32'h0));
        vecs.push_back(mk(1, SH,    32'h22, 32'h1234_BEEF, 32'h0,         0, 3, 32'hBEEF_0000));
        vecs.push_back(mk(0, LW,    32'h20, 32'h0,         32'hBEEF_0000, 0, 2, 32'h0));
        vecs.push_back(mk(0, LH,    32'h22, 32'h0,         32'hFFFF_BEEF, 0, 2, 32'h0));
        vecs.push_back(mk(0, LHU,   32'h22, 32'h0,         32'h0000_BEEF, 0, 2, 32'h0));
        vecs.push_back(mk(0, LW,    32'h06, 32'h0,         32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(1, SH,    32'h03, 32'hFFFF,      32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(1, SW,    32'h80, 32'hDEAD_BEEF, 32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(0, 3'd3,  32'h00, 32'h0,         32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(1, SW,    32'h7C, 32'h80FF_7F01, 32'h0,         0, 2, 32'h80FF_7F01));
        vecs.push_back(mk(0, LB,    32'h7F, 32'h0,         32'hFFFF_FF80, 0, 2, 32'h0));
        vecs.push_back(mk(0, LBU,   32'h7E, 32'h0,         32'h0000_00FF, 0, 2, 32'h0));
        vecs.push_back(mk(0, LB,    32'h7C, 32'h0,         32'h0000_0001, 0, 2, 32'h0));
        vecs.push_back(mk(0, LH,    32'h7E, 32'h0,         32'hFFFF_80FF, 0, 2, 32'h0));
        vecs.push_back(mk(0, LH,    32'h11, 32'h0,         32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(0, LW,    32'h83, 32'h0,         32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(0, LB,    32'h80, 32'h0,         32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(1, 3'd4,  32'h00, 32'h5,         32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(1, 3'd3,  32'h00, 32'h5,         32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(0, 3'd6,  32'h00, 32'h0,         32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(0, 3'd7,  32'h00, 32'h0,         32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(1, SB,    32'h7F, 32'h0000_00AA, 32'h0,         0, 3, 32'hAAFF_7F01));
        vecs.push_back(mk(0, LW,    32'h7C, 32'h0,         32'hAAFF_7F01, 0, 2, 32'h0));

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, e, lat, wens);
            model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, m_rd, m_e, m_lat, m_wens, m_ww);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_wen_count", i), 32'(wens),
                (vecs[i].we && !vecs[i].exp_err) ? 32'd1 : 32'd0);
            if (vecs[i].we && !vecs[i].exp_err) begin
                chk($sformatf("vec%0d_wr_addr", i), wen_addr_s, {vecs[i].addr[31:2], 2'b00});
                chk($sformatf("vec%0d_wr_data", i), wen_data_s, vecs[i].exp_wword);
            end
        end

        // req_valid held high: re-accepted only once back in IDLE
        exp_ready = 6'b100100;   // bit k = expectation after edge k
        exp_wen   = 6'b001001;
        exp_valid = 6'b010010;
        w0 = wen_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = SW; req_addr = 32'h04; req_wdata = 32'h1234_5678;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold_ready_e%0d", k), 32'(req_ready),  32'(exp_ready[k]));
            chk($sformatf("hold_wen_e%0d", k),   32'(mem_wen),    32'(exp_wen[k]));
            chk($sformatf("hold_valid_e%0d", k), 32'(resp_valid), 32'(exp_valid[k]));
            if (k == 3) req_valid = 1'b0;
        end
        chk("hold_wen_total", 32'(wen_cnt - w0), 32'd2);
        $display("txn held-valid sw addr=0x00000004 wens=%0d", wen_cnt - w0);
        model(1'b1, SW, 32'h04, 32'h1234_5678, m_rd, m_e, m_lat, m_wens, m_ww);
        do_req(1'b0, LW, 32'h04, 32'h0, rd, e, lat, wens);
        chk("hold_readback", rd, 32'h1234_5678);
        model(1'b0, LW, 32'h04, 32'h0, m_rd, m_e, m_lat, m_wens, m_ww);

        // Reset during the read phase of an sb aborts it cleanly
        do_req(1'b1, SW, 32'h40, 32'hCAFE_BABE, rd, e, lat, wens);
        model(1'b1, SW, 32'h40, 32'hCAFE_BABE, m_rd, m_e, m_lat, m_wens, m_ww);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = SB; req_addr = 32'h41; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_in_rd_ready", 32'(req_ready), 32'd0);
        w0 = wen_cnt;
        r0 = resp_cnt;
        #2 rst = 1'b0;
        #1;
        chk("abort_wen_low",   32'(mem_wen),    32'd0);
        chk("abort_valid_low", 32'(resp_valid), 32'd0);
        chk("abort_ready_async", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_no_write", 32'(wen_cnt - w0),  32'd0);
        chk("abort_no_resp",  32'(resp_cnt - r0), 32'd0);
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        $display("txn reset-abort sb addr=0x00000041 wens=%0d resps=%0d", wen_cnt - w0, resp_cnt - r0);
        do_req(1'b0, LW, 32'h40, 32'h0, rd, e, lat, wens);
        chk("abort_word_unchanged", rd, 32'hCAFE_BABE);
        model(1'b0, LW, 32'h40, 32'h0, m_rd, m_e, m_lat, m_wens, m_ww);

        // Random traffic against the reference model
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(128, 160));
                1:       a = $urandom();
                default: a = 32'($urandom_range(0, 127));
            endcase
            wd = $urandom();
            do_req(we, f3, a, wd, rd, e, lat, wens);
            m_waddr = {a[31:2], 2'b00};
            model(we, f3, a, wd, m_rd, m_e, m_lat, m_wens, m_ww);
            chk($sformatf("rnd%0d_rdata", n), rd, m_rd);
            chk($sformatf("rnd%0d_err", n), 32'(e), 32'(m_e));
            chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(m_lat));
            chk($sformatf("rnd%0d_wen_count", n), 32'(wens), 32'(m_wens));
            if (m_wens == 1 && wens == 1) begin
                chk($sformatf("rnd%0d_wr_addr", n), wen_addr_s, m_waddr);
                chk($sformatf("rnd%0d_wr_data", n), wen_data_s, m_ww);
            end
        end

        // Final memory image matches the model byte for byte
        for (int w = 0; w < MEM_BYTES / 4; w++) begin
            chk($sformatf("final_mem_word%0d", w), mem[w],
                {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequencer between the core's execute stage and the unified byte-addressed instruction/data memory.
- Accepts one load or store request at a time and checks alignment, range and funct3 legality.
- Sub-word stores are done as read-modify-write, because the memory's write port always writes four bytes.
- Loaded bytes and halfwords are sign- or zero-extended; one result is returned per request.

Parameters:
- MEM_BYTES, 128: memory size in bytes. A request whose word-aligned address is >= MEM_BYTES is out of range.
- ADDR_W, 32: width of the request and memory address buses.

Ports:
- clk  in  1  clock; every register samples on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for sb/sh.
- resp_valid  out  1  one-cycle result pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out of range, or illegal funct3.
- mem_addr  out  ADDR_W  word-aligned address to memory.
- mem_wdata  out  32  word to write.
- mem_wen  out  1  memory write enable.
- mem_rdata  in  32  combinational memory read data.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0, mem_wen=0, mem_addr=0, mem_wdata=0, req_ready=1.
  - A reset mid-operation aborts the request with no response. mem_wen drops immediately, so no partial write occurs.
- Handshake:
  - A request is accepted when req_valid && req_ready in IDLE.
  - Address, we, funct3 and wdata are latched at acceptance.
  - There is no response backpressure; the core stalls until resp_valid.
- Legal funct3:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other code is an error.
- Alignment:
  - Halfword accesses need addr[0]=0.
  - Word accesses need addr[1:0]=00.
  - Byte accesses are always aligned.
- Range: word-aligned address = {addr[ADDR_W-1:2],2'b00}; it must be < MEM_BYTES.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE -> RESP when the request has an error.
  - IDLE -> RD for a load, sb or sh.
  - IDLE -> WR for sw.
  - RD -> RESP for a load; mem_rdata is captured, lane-extracted and extended.
  - RD -> WR for sb/sh; mem_rdata is captured and merged.
  - WR -> RESP.
  - RESP -> IDLE.
- Latency, counted in cycles after the acceptance edge until resp_valid is high:
  - error: 1
  - load: 2
  - sw: 2
  - sb/sh: 3
  - The next request can be accepted the cycle after RESP.
- Memory drive:
  - mem_addr holds the aligned address from RD through WR.
  - mem_wen=1 only in WR, for exactly one cycle.
  - An error request never asserts mem_wen.
- Lane extract (loads): lane = addr[1:0].
  - Byte = mem_rdata[8*lane+7 : 8*lane].
  - Halfword = mem_rdata[16*addr[1]+15 : 16*addr[1]].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Merge (stores):
  - sb replaces only byte lane addr[1:0] of the captured word with wdata[7:0].
  - sh replaces halfword addr[1] with wdata[15:0].
  - All other bytes keep their read value.
- RESP outputs:
  - resp_valid=1 for one cycle, with resp_err and resp_rdata.
  - resp_rdata=0 for stores and errors.
  - Outside RESP, resp_valid=0 and resp_rdata holds its last value.
- req_valid while busy is ignored; there is no queueing.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The FSM state enum (IDLE, RD, WR, RESP).
  - Alignment-check function.
- One natural sub-module, lsu_lane_align. It is purely combinational and holds:
  - extract+extend: rdata, funct3, addr[1:0] -> 32-bit result.
  - merge: old word, wdata, funct3, addr[1:0] -> new word.

Test Plan:
- Memory word 0x10 = 0x8877_6655; lb at addr 0x13 -> resp_valid 2 cycles after acceptance, resp_rdata=0xFFFF_FF88, err=0. lbu at 0x13 -> 0x0000_0088.
- Word 0x20 = 0xAABB_CCDD; sb 0x11 at addr 0x21 -> one WR cycle with mem_addr=0x20, mem_wdata=0xAABB_11DD; resp 3 cycles after acceptance; a subsequent lw at 0x20 returns 0xAABB_11DD.
- sh 0xBEEF at addr 0x22 over 0x0000_0000 -> memory word becomes 0xBEEF_0000. lh at 0x22 -> 0xFFFF_BEEF; lhu -> 0x0000_BEEF.
- Error cases, each checked for resp_err=1 one cycle after acceptance and mem_wen never high:
  - lw at 0x06 (misaligned).
  - sh at 0x03 (misaligned).
  - sw at addr 0x80 with MEM_BYTES=128 (out of range).
  - funct3=011 (illegal).
- sw 0x1234_5678 at 0x04 -> mem_wen high for exactly one cycle, resp 2 cycles after acceptance. req_valid held high throughout is re-accepted only in IDLE; req_ready=0 in RD/WR/RESP.
- Assert rst low during the RD cycle of an sb -> mem_wen never asserts, resp_valid stays 0, target word is unchanged, req_ready=1 after release.
